sha256_msg_ctrl: RTL and testbench

- Message sequencer in front of the sha256 core.
- Accepts an arbitrary-length byte message as a 32-bit word stream and buffers it into 16-word blocks.
- Applies SHA-256 padding and the 64-bit length field, bursts each block into the core, and waits for the core's finish pulse between blocks.
- Re-initialises the core's hash state at the start of every message and flags when the core hash outputs hold the final digest.

---
 rtl/sha256_msg_ctrl.sv | 139 +++++++++++++
 tb/tb_sha256_msg_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_ctrl.sv
// sha256_msg_ctrl: buffers a byte message into 16-word blocks, pads it, and feeds the sha256 core
//   clk, rst_n         clock, synchronous active-low reset
//   s_valid/s_ready    input word handshake; s_data byte 0 in [7:0]
//   s_last, s_keep     final word marker and its valid byte count (1..4, 0 or >4 means 4)
//   core_rst_n_o       core hash re-init, low for one cycle per message
//   core_dat_vaild_o   16-cycle block burst strobe, core_dat_o carries the words
//   core_busy_i        core still compressing; a burst only starts when low
//   core_finish_i      core finished the block just sent
//   busy_o             controller active (not IDLE)
//   done_o             one-cycle pulse once the core holds the final digest
module sha256_msg_ctrl #(
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic [2:0]  s_keep,
  output logic        core_rst_n_o,
  output logic        core_dat_vaild_o,
  output logic [31:0] core_dat_o,
  input  logic        core_busy_i,
  input  logic        core_finish_i,
  output logic        busy_o,
  output logic        done_o
);
  typedef enum logic [2:0] {IDLE, INIT, FILL, PAD, SEND, WAIT, DONE} state_t;
  state_t state;
  logic [31:0] blk [16];
  logic [4:0] idx, cnt;
  logic [LEN_W-1:0] bytes;
  logic pad_flag, fin, eom;
  logic [2:0] keep, step;
  logic [31:0] tail;
  logic [63:0] len;
  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
  assign keep = (s_keep == 3'd0 || s_keep > 3'd4) ? 3'd4 : s_keep;
  assign step = s_last ? keep : 3'd4;
  assign len = 64'({bytes, 3'b000});
  // final word: keep valid lanes, 0x80 in the first unused lane, zeros above
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign tail[8*i +: 8] = 3'(i) < keep ? s_data[8*i +: 8] : 3'(i) == keep ? 8'h80 : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      s_ready <= 1'b0;
      core_rst_n_o <= 1'b0;
      core_dat_vaild_o <= 1'b0;
      core_dat_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      bytes <= '0;
      idx <= '0;
      cnt <= '0;
      pad_flag <= 1'b0;
      fin <= 1'b0;
      eom <= 1'b0;
    end else begin
      core_rst_n_o <= 1'b1;
      core_dat_vaild_o <= 1'b0;
      done_o <= 1'b0;
      case (state)
        IDLE: if (s_valid) begin
          state <= INIT;
          core_rst_n_o <= 1'b0;
          busy_o <= 1'b1;
        end
        INIT: begin
          state <= FILL;
          s_ready <= 1'b1;
          bytes <= '0;
          idx <= '0;
          pad_flag <= 1'b0;
          fin <= 1'b0;
          eom <= 1'b0;
        end
        FILL: if (s_valid && s_ready) begin
          blk[idx[3:0]] <= s_last ? tail : s_data;
          bytes <= bytes + LEN_W'(step);
          idx <= idx + 5'd1;
          if (s_last) begin
            state <= PAD;
            s_ready <= 1'b0;
            pad_flag <= keep != 3'd4;
            eom <= 1'b1;
          end else if (idx == 5'd15) begin
            state <= SEND;
            s_ready <= 1'b0;
            fin <= 1'b0;
          end
        end
        PAD: if (idx < 5'd14) begin
          blk[idx[3:0]] <= pad_flag ? 32'h0 : 32'h80;
          pad_flag <= 1'b1;
          idx <= idx + 5'd1;
        end else begin
          state <= SEND;
          fin <= idx == 5'd14 && pad_flag;
          if (idx == 5'd14) begin
            blk[14] <= pad_flag ? bswap(len[63:32]) : 32'h80;
            blk[15] <= pad_flag ? bswap(len[31:0]) : 32'h0;
          end
          if (idx == 5'd15) blk[15] <= pad_flag ? 32'h0 : 32'h80;
          // a full block with no room left keeps pad_flag clear so the 0x80 lands in the next block
          if (idx != 5'd16) pad_flag <= 1'b1;
        end
        SEND: if (cnt == 5'd16) begin
          state <= WAIT;
          cnt <= '0;
        end else if (cnt != 5'd0 || !core_busy_i) begin
          core_dat_vaild_o <= 1'b1;
          core_dat_o <= blk[cnt[3:0]];
          cnt <= cnt + 5'd1;
        end
        WAIT: if (core_finish_i) begin
          idx <= '0;
          if (fin) begin
            state <= DONE;
            done_o <= 1'b1;
          end else if (eom) state <= PAD;
          else begin
            state <= FILL;
            s_ready <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// tb_sha256_msg_ctrl: scoreboard bench with a behavioural sha256 core behind the controller
module tb_sha256_msg_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_last = 1'b0, force_busy = 1'b0, rst_q = 1'b0;
  logic [31:0] s_data = '0;
  logic [2:0] s_keep = '0;
  logic s_ready, core_rst_n_o, core_dat_vaild_o, core_busy_i, core_finish_i, busy_o, done_o, mbusy;
  logic [31:0] core_dat_o;
  logic [3:0] wcnt, lat;
  logic [511:0] cblk;
  logic [255:0] hs;
  logic prev_busy = 1'b0, prev_fin = 1'b0, prev_done = 1'b0;
  int n_cmp = 0, n_bad = 0, run = 0, low_cnt = 0, n_burst = 0, n_done = 0, nb0 = 0, nd0 = 0, nblk = 0;
  logic [31:0] exp_q [$];
  logic [255:0] dig_q [$];
  logic [7:0] msg [128];
  logic [7:0] pm [256];
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D56 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  always #5 clk = ~clk;
  assign core_busy_i = mbusy | force_busy;
  sha256_msg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_keep(s_keep), .core_rst_n_o(core_rst_n_o), .core_dat_vaild_o(core_dat_vaild_o),
    .core_dat_o(core_dat_o), .core_busy_i(core_busy_i), .core_finish_i(core_finish_i),
    .busy_o(busy_o), .done_o(done_o)
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsw(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
  function automatic logic [255:0] sha_blk(input logic [255:0] h, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
           + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
    {a, b, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction
  always @(posedge clk) begin
    rst_q <= rst_n;
    if (!core_rst_n_o) begin
      hs <= IV; wcnt <= '0; mbusy <= 1'b0; core_finish_i <= 1'b0; lat <= '0; cblk <= '0;
    end else begin
      core_finish_i <= 1'b0;
      if (core_dat_vaild_o) begin
        cblk <= {cblk[479:0], bsw(core_dat_o)};
        wcnt <= wcnt + 4'd1;
        if (wcnt == 4'd15) begin mbusy <= 1'b1; lat <= 4'd6; end
      end
      if (mbusy) begin
        if (lat == 4'd0) begin
          hs <= sha_blk(hs, cblk); mbusy <= 1'b0; core_finish_i <= 1'b1;
        end else lat <= lat - 4'd1;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst_q) begin
      run = 0; low_cnt = 0; prev_busy = 1'b0; prev_fin = 1'b0; prev_done = 1'b0;
    end else begin
      if (!core_rst_n_o) low_cnt++;
      if (core_dat_vaild_o) begin
        if (run == 0) begin
          chk("burst_start_busy", prev_busy, 0);
          n_burst++;
        end
        run++;
        if (exp_q.size() == 0) chk("unexpected_word", core_dat_o, 0);
        else chk("blk_word", core_dat_o, exp_q.pop_front());
      end else if (run != 0) begin
        chk("burst_len", run, 16);
        run = 0;
      end
      if (done_o) begin
        chk("done_after_finish", prev_fin, 1);
        chk("done_single", prev_done, 0);
        chk("busy_in_done", busy_o, 1);
        chk("init_pulses", low_cnt, 1);
        low_cnt = 0;
        if (dig_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("digest", hs, dig_q.pop_front());
        chk("words_left", exp_q.size(), 0);
        n_done++;
      end
      prev_busy = core_busy_i; prev_fin = core_finish_i; prev_done = done_o;
    end
  end
  task automatic set_str(input string s);
    for (int i = 0; i < 128; i++) msg[i] = 8'($urandom);
    for (int i = 0; i < s.len(); i++) msg[i] = s[i];
  endtask
  task automatic set_rand();
    for (int i = 0; i < 128; i++) msg[i] = 8'($urandom);
  endtask
  task automatic start_msg(input int n, input bit bub, input bit k0, input bit known, input logic [255:0] kd);
    int tot;
    logic [63:0] l;
    logic [511:0] b;
    logic [255:0] dg;
    bit ok, last;
    tot = ((n + 8) / 64 + 1) * 64;
    l = 64'(n) * 64'd8;
    for (int i = 0; i < tot; i++) pm[i] = i < n ? msg[i] : (i == n ? 8'h80 : 8'h00);
    for (int i = 0; i < 8; i++) pm[tot-1-i] = l[8*i +: 8];
    dg = IV;
    for (int k = 0; k < tot / 64; k++) begin
      for (int j = 0; j < 16; j++) begin
        exp_q.push_back({pm[64*k+4*j+3], pm[64*k+4*j+2], pm[64*k+4*j+1], pm[64*k+4*j]});
        b[511-32*j -: 32] = {pm[64*k+4*j], pm[64*k+4*j+1], pm[64*k+4*j+2], pm[64*k+4*j+3]};
      end
      dg = sha_blk(dg, b);
    end
    dig_q.push_back(known ? kd : dg);
    nblk = tot / 64; nb0 = n_burst; nd0 = n_done;
    for (int i = 0; i < n; i += 4) begin
      int t = 0;
      last = i + 4 >= n;
      if (bub) while ($urandom_range(0, 2) == 0) begin
        s_valid = 1'b0; s_data = $urandom;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data = {msg[i+3], msg[i+2], msg[i+1], msg[i]};
      s_last = last;
      s_keep = last ? 3'(n - i) : 3'($urandom_range(0, 7));
      if (last && k0 && n - i == 4) s_keep = 3'd0;
      do begin
        @(negedge clk); ok = s_ready;
        @(posedge clk); #1; t++;
      end while (!ok && t < 300);
      if (!ok) chk("s_ready_timeout", ok, 1);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask
  task automatic finish_msg();
    int t = 0;
    while (n_done == nd0 && t < 3000) begin @(posedge clk); t++; end
    if (n_done == nd0) begin
      chk("done_timeout", n_done - nd0, 1);
      exp_q.delete(); dig_q.delete();
    end
    chk("bursts", n_burst - nb0, nblk);
    @(negedge clk);
    chk("idle_after_done", busy_o, 0);
    @(posedge clk); #1;
  endtask
  task automatic run_msg(input int n, input bit bub, input bit k0, input bit known, input logic [255:0] kd);
    start_msg(n, bub, k0, known, kd);
    finish_msg();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lens [12] = '{1, 4, 5, 52, 55, 57, 58, 60, 61, 63, 65, 120};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_vaild", core_dat_vaild_o, 0);
    chk("rst_dat", core_dat_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_core_rst_n", core_rst_n_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_core_rst_n", core_rst_n_o, 1);
    chk("idle_s_ready", s_ready, 0);
    @(posedge clk); #1;
    set_str("abc");
    run_msg(3, 0, 0, 1, ABC);
    set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    run_msg(56, 0, 0, 1, D56);
    set_rand();
    run_msg(64, 0, 1, 0, '0);
    set_rand();
    force_busy = 1'b1;
    start_msg(8, 1, 0, 0, '0);
    repeat (22) @(posedge clk);
    @(negedge clk);
    chk("no_burst_forced", n_burst - nb0, 0);
    @(posedge clk); #1 force_busy = 1'b0;
    finish_msg();
    set_str("abc");
    run_msg(3, 0, 0, 1, ABC);
    run_msg(3, 0, 0, 1, ABC);
    start_msg(3, 0, 0, 1, ABC);
    for (int t = 0; t < 300 && run != 7; t++) @(posedge clk);
    if (run != 7) chk("burst7_timeout", run, 7);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_vaild", core_dat_vaild_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_core_rst_n", core_rst_n_o, 0);
    exp_q.delete(); dig_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    run_msg(3, 0, 0, 1, ABC);
    foreach (lens[i]) begin
      set_rand();
      run_msg(lens[i], 1, 1'($urandom_range(0, 1)), 0, '0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
